// File: rtl/counter_pkg.sv
// Shared constants for the programmable index counter.
package counter_pkg;

    localparam int unsigned COUNTER_BITS = 8;

endpackage : counter_pkg

// File: rtl/counter.sv
// Programmable up-counter: steps by count_by_i from start_val_i toward end_val_i, then wraps.
// Optional simulation checks are compiled in when COUNTER_ASSERT_EN is defined.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned Bits = COUNTER_BITS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [Bits-1:0] start_val_i,
    input  logic [Bits-1:0] end_val_i,
    input  logic [Bits-1:0] count_by_i,
    input  logic            assert_on_i,
    output logic [Bits-1:0] count_o
);

    logic [Bits-1:0] r_count;
    logic            r_started;
    logic [Bits-1:0] w_cur;
    logic [Bits-1:0] w_next;

    // Until the first enabled edge the output tracks start_val_i live.
    always_comb begin
        w_cur  = r_started ? r_count : start_val_i;
        w_next = w_cur + count_by_i;
        if (w_cur >= end_val_i) begin
            w_next = start_val_i + count_by_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count   <= '0;
            r_started <= 1'b0;
        end else if (en_i) begin
            r_count   <= w_next;
            r_started <= 1'b1;
        end
    end

    assign count_o = w_cur;

`ifdef COUNTER_ASSERT_EN
    a_start_le_end : assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
        start_val_i <= end_val_i)
        else $error("counter: start_val_i %0h above end_val_i %0h", start_val_i, end_val_i);

    a_step_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
        count_by_i != '0)
        else $error("counter: count_by_i is zero");

    a_en_known : assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
        !$isunknown(en_i))
        else $error("counter: en_i is unknown");
`else
    logic w_unused_assert_on;
    assign w_unused_assert_on = assert_on_i;
`endif

endmodule : counter

// File: tb/tb_counter.sv
// Directed scoreboard bench for counter: expected values queued at stimulus, popped at sample.
module tb_counter;

    logic       clk_i;
    logic       rst_ni;
    logic       en_i;
    logic [7:0] start_val_i;
    logic [7:0] end_val_i;
    logic [7:0] count_by_i;
    logic       assert_on_i;
    logic [7:0] count_o;

    int unsigned n_pass;
    int unsigned n_total;
    logic [7:0]  sb_q[$];

    counter #(.Bits(8)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .start_val_i(start_val_i),
        .end_val_i  (end_val_i),
        .count_by_i (count_by_i),
        .assert_on_i(assert_on_i),
        .count_o    (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input logic [7:0] v);
        sb_q.push_back(v);
    endtask

    // Compare count_o now against the oldest queued expectation.
    task automatic check_now(input string tag);
        logic [7:0] exp;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL %s: observed %h, expected value missing from scoreboard", tag, count_o);
        end else begin
            exp = sb_q.pop_front();
            assert (count_o === exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", tag, count_o, exp);
        end
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk_i);
        #1;
        check_now(tag);
    endtask

    // Called 1 time unit after a rising edge; the pulse ends well before the next edge.
    task automatic pulse_reset();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        assert_on_i = 1'b1;
        rst_ni      = 1'b0;
        en_i        = 1'b1;
        start_val_i = 8'h55;
        end_val_i   = 8'hFF;
        count_by_i  = 8'h01;

        // Reset view, then release with no edge in between
        #12;
        expect_val(8'h55);
        check_now("reset_hold");
        rst_ni = 1'b1;
        #1;
        expect_val(8'h55);
        check_now("reset_release");

        // Step 1, wrapping at 0A
        start_val_i = 8'h00;
        end_val_i   = 8'h0A;
        count_by_i  = 8'h01;
        for (int i = 1; i <= 16; i++) begin
            expect_val((i <= 10) ? 8'(i) : 8'(i - 10));
            edge_check("step1");
        end

        // Step 3 from 02 to 0E
        pulse_reset();
        start_val_i = 8'h02;
        end_val_i   = 8'h0E;
        count_by_i  = 8'h03;
        #1;
        expect_val(8'h02);
        check_now("step3_idle");
        begin
            logic [7:0] seq3 [6];
            seq3 = '{8'h05, 8'h08, 8'h0B, 8'h0E, 8'h05, 8'h08};
            for (int i = 0; i < 6; i++) begin
                expect_val(seq3[i]);
                edge_check("step3");
            end
        end

        // Enable gating
        pulse_reset();
        start_val_i = 8'h00;
        end_val_i   = 8'hFF;
        count_by_i  = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            expect_val(8'(i));
            edge_check("gate_run");
        end
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_val(8'h05);
            edge_check("gate_hold");
        end

        // Async reset mid-count
        en_i = 1'b1;
        expect_val(8'h06);
        edge_check("pre_rst");
        expect_val(8'h07);
        edge_check("pre_rst");
        en_i        = 1'b0;
        start_val_i = 8'h20;
        #1;
        expect_val(8'h07);
        check_now("start_change_started");
        rst_ni = 1'b0;
        #1;
        expect_val(8'h20);
        check_now("async_reset");
        en_i = 1'b1;
        expect_val(8'h20);
        edge_check("reset_held_edge");

        // Overflow: FE+07 wraps modulo 256 to 05, which is below end so counting continues
        #2;
        rst_ni      = 1'b1;
        start_val_i = 8'hF0;
        end_val_i   = 8'hFF;
        count_by_i  = 8'h07;
        begin
            logic [7:0] seq6 [4];
            seq6 = '{8'hF7, 8'hFE, 8'h05, 8'h0C};
            for (int i = 0; i < 4; i++) begin
                expect_val(seq6[i]);
                edge_check("overflow");
            end
        end

        // Overshoot above end is kept, next edge wraps
        pulse_reset();
        start_val_i = 8'h02;
        end_val_i   = 8'h09;
        count_by_i  = 8'h04;
        begin
            logic [7:0] seq7 [3];
            seq7 = '{8'h06, 8'h0A, 8'h06};
            for (int i = 0; i < 3; i++) begin
                expect_val(seq7[i]);
                edge_check("overshoot");
            end
        end

        // Zero step holds; a new step size applies at the next enabled edge
        pulse_reset();
        assert_on_i = 1'b0;
        start_val_i = 8'h03;
        end_val_i   = 8'h10;
        count_by_i  = 8'h00;
        expect_val(8'h03);
        edge_check("zero_step");
        expect_val(8'h03);
        edge_check("zero_step");
        count_by_i  = 8'h05;
        assert_on_i = 1'b1;
        expect_val(8'h08);
        edge_check("step_change");
        expect_val(8'h0D);
        edge_check("step_change");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_counter
